seq_multiplier: RTL

Parametrised iterative shift-add multiplier for the processor execution unit. It replaces the purely combinational 8×8 array multiplier with a `WIDTH`-bit engine that produces one partial product per cycle. It supports unsigned (MUL) and two's-complement signed (IMUL) operation, uses a start/busy/done handshake, and computes the 8086 CF/OF significance flag. The ALU control sequencer drives it and stalls on `busy`.

---
 rtl/seq_multiplier_if.sv | 24 ++
 rtl/seq_multiplier.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seq_multiplier_if.sv
// Request/result bundle between the ALU control sequencer (master) and the multiplier (slave).
// Operands and mode travel with start; busy/done/Mult/cf_of come back.
interface seq_multiplier_if #(
   parameter int WIDTH = 8
);
   logic                 start;
   logic                 signed_mode;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   Mult;
   logic                 cf_of;

   modport master (
      output start, signed_mode, A, B,
      input  busy, done, Mult, cf_of
   );

   modport slave (
      input  start, signed_mode, A, B,
      output busy, done, Mult, cf_of
   );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add MUL/IMUL with 8086 CF/OF flag; signed support only when SEQ_MULT_SIGNED_EN is defined.
// Latency WIDTH cycles from accepting edge to done; start is ignored while busy, so the sequencer stalls on busy.
module seq_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   seq_multiplier_if.slave  mul
);
   localparam int W     = WIDTH;
   localparam int CNT_W = $clog2(WIDTH);

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2*W:0]      acc_q, acc_d;     // {partial sum (W+1), unconsumed multiplier bits}
   logic [W-1:0]      mcand_q, mcand_d;
   logic [2*W-1:0]    mult_q, mult_d;
   logic              cf_q, cf_d;

   logic [W:0]        sum;
   logic [2*W:0]      step;
   logic [2*W-1:0]    res;
   logic              cf_next;
   logic              accept;
   logic [W-1:0]      mag_a, mag_b;

`ifdef SEQ_MULT_SIGNED_EN
   logic              neg_q, neg_d, neg_cap;
   logic              sm_q, sm_d;
`else
   logic              unused_signed_mode;
   assign unused_signed_mode = mul.signed_mode;
`endif

   // Signed operands are reduced to magnitudes; -2^(W-1) negates to itself, which reads correctly as unsigned.
   always_comb begin
      mag_a = mul.A;
      mag_b = mul.B;
`ifdef SEQ_MULT_SIGNED_EN
      neg_cap = 1'b0;
      if (mul.signed_mode) begin
         mag_a   = mul.A[W-1] ? -mul.A : mul.A;
         mag_b   = mul.B[W-1] ? -mul.B : mul.B;
         neg_cap = mul.A[W-1] ^ mul.B[W-1];
      end
`endif
   end

   always_comb begin
      sum  = acc_q[2*W:W] + (acc_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
      step = {1'b0, sum, acc_q[W-1:1]};
   end

   // Final product and flag are taken from the last step directly so they land on the DONE edge.
   always_comb begin
      res     = step[2*W-1:0];
      cf_next = |res[2*W-1:W];
`ifdef SEQ_MULT_SIGNED_EN
      if (neg_q) begin
         res = -step[2*W-1:0];
      end
      if (sm_q) begin
         cf_next = (res[2*W-1:W] != {W{res[W-1]}});
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mcand_d = mcand_q;
      mult_d  = mult_q;
      cf_d    = cf_q;
      accept  = 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_d   = neg_q;
      sm_d    = sm_q;
`endif
      case (state_q)
         ST_IDLE: begin
            accept = mul.start;
         end
         ST_RUN: begin
            acc_d = step;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(W-1)) begin
               state_d = ST_DONE;
               cnt_d   = '0;
               mult_d  = res;
               cf_d    = cf_next;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            accept  = mul.start;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         state_d = ST_RUN;
         cnt_d   = '0;
         mcand_d = mag_a;
         acc_d   = {{(W+1){1'b0}}, mag_b};
`ifdef SEQ_MULT_SIGNED_EN
         neg_d   = neg_cap;
         sm_d    = mul.signed_mode;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         mcand_q <= '0;
         mult_q  <= '0;
         cf_q    <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q   <= 1'b0;
         sm_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mcand_q <= mcand_d;
         mult_q  <= mult_d;
         cf_q    <= cf_d;
`ifdef SEQ_MULT_SIGNED_EN
         neg_q   <= neg_d;
         sm_q    <= sm_d;
`endif
      end
   end

   assign mul.busy  = (state_q == ST_RUN);
   assign mul.done  = (state_q == ST_DONE);
   assign mul.Mult  = mult_q;
   assign mul.cf_of = cf_q;
endmodule
